// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt/exception controller.
// Cause codes reported on o_cause / CAUSE, and special-register offsets
// relative to the block's base address.
package irq_ctrl_pkg;

  // Cause codes; code 3 is reserved, external line k reports CAUSE_EXT_BASE+k.
  localparam int CAUSE_MEM      = 0;
  localparam int CAUSE_TRAP     = 1;
  localparam int CAUSE_SYS      = 2;
  localparam int CAUSE_EXT_BASE = 4;

  // Register offsets from the base address.
  localparam int OFF_MASK  = 0;
  localparam int OFF_MODE  = 1;
  localparam int OFF_PEND  = 2;
  localparam int OFF_CAUSE = 3;
  localparam int OFF_RAW   = 4;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser plus one history flop for rising-edge detection.
// Ports: clk/rst (sync active-high), din async line in, s synchronised
// level (SYNC_STAGES flops, or din directly when 0), s_d previous s.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic s_d
);

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;

      always_ff @(posedge clk) begin
        if (rst) begin
          chain <= '0;
        end else begin
          chain[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/exception controller: N_IRQ synchronised lines with edge/level
// mode, pending latch, mask and fixed priority, plus three sync exceptions.
// Ports: i_irq lines, i_irq_en global enable, exception inputs, special-
// register bus (addr/data/we -> data/hit), o_irq/o_cause take request.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int RW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SR_BASE     = 'h20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_irq_en,
  input  logic             i_sys,
  input  logic             i_trap,
  input  logic             i_mem_exception,
  input  logic [RW-1:0]    i_sr_addr,
  input  logic [RW-1:0]    i_sr_data,
  input  logic             i_sr_we,
  output logic [RW-1:0]    o_sr_data,
  output logic             o_sr_hit,
  output logic             o_irq,
  output logic [RW-1:0]    o_cause
);

  localparam int            IW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [RW-1:0] BASE = RW'(SR_BASE);

  logic [N_IRQ-1:0] s, s_d, rise;
  logic [N_IRQ-1:0] mask, mode, pend_q, pend;
  logic [N_IRQ-1:0] mode_nxt, w1c, take_clr, pend_nxt, ext_req;
  logic [RW-1:0]    cause_q, off;
  logic [IW-1:0]    ext_idx;
  logic             ext_any;
  logic             wr_mask, wr_mode, wr_pend;
  logic             unused_data;

  // Data bits above N_IRQ are don't-care on writes.
  assign unused_data = ^i_sr_data;

  generate
    for (genvar k = 0; k < N_IRQ; k++) begin : g_line
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (i_clk),
        .rst (i_rst),
        .din (i_irq[k]),
        .s   (s[k]),
        .s_d (s_d[k])
      );
    end
  endgenerate

  assign rise = s & ~s_d;
  // Level lines follow the synchronised input; edge lines use the latch.
  assign pend = (pend_q & mode) | (s & ~mode);

  // Register decode
  assign off      = i_sr_addr - BASE;
  assign o_sr_hit = (i_sr_addr >= BASE) && (off <= RW'(OFF_RAW));
  assign wr_mask  = i_sr_we && o_sr_hit && (off == RW'(OFF_MASK));
  assign wr_mode  = i_sr_we && o_sr_hit && (off == RW'(OFF_MODE));
  assign wr_pend  = i_sr_we && o_sr_hit && (off == RW'(OFF_PEND));

  always_comb begin
    o_sr_data = '0;
    if (o_sr_hit) begin
      case (off)
        RW'(OFF_MASK):  o_sr_data[N_IRQ-1:0] = mask;
        RW'(OFF_MODE):  o_sr_data[N_IRQ-1:0] = mode;
        RW'(OFF_PEND):  o_sr_data[N_IRQ-1:0] = pend;
        RW'(OFF_CAUSE): o_sr_data            = cause_q;
        RW'(OFF_RAW):   o_sr_data[N_IRQ-1:0] = s;
        default:        o_sr_data            = '0;
      endcase
    end
  end

  // Fixed-priority arbitration; lowest external index wins among lines.
  always_comb begin
    ext_req  = pend & mask & {N_IRQ{i_irq_en}};
    ext_any  = |ext_req;
    ext_idx  = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (ext_req[k]) ext_idx = IW'(k);
    end
    take_clr = '0;
    o_irq    = 1'b1;
    o_cause  = '0;
    if (i_mem_exception) begin
      o_cause = RW'(CAUSE_MEM);
    end else if (i_trap) begin
      o_cause = RW'(CAUSE_TRAP);
    end else if (i_sys) begin
      o_cause = RW'(CAUSE_SYS);
    end else if (ext_any) begin
      o_cause           = RW'(CAUSE_EXT_BASE) + RW'(ext_idx);
      take_clr[ext_idx] = 1'b1;
    end else begin
      o_irq = 1'b0;
    end
  end

  // Set beats clear; masking with the next MODE drops latched bits of lines
  // being switched to level.
  assign mode_nxt = wr_mode ? i_sr_data[N_IRQ-1:0] : mode;
  assign w1c      = wr_pend ? i_sr_data[N_IRQ-1:0] : '0;
  assign pend_nxt = ((pend_q & ~(w1c | take_clr)) | (rise & mode)) & mode_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask    <= '0;
      mode    <= '0;
      pend_q  <= '0;
      cause_q <= '0;
    end else begin
      if (wr_mask) mask <= i_sr_data[N_IRQ-1:0];
      mode   <= mode_nxt;
      pend_q <= pend_nxt;
      if (o_irq) cause_q <= o_cause;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with default parameters
// (N_IRQ=8, RW=16, SYNC_STAGES=2, SR_BASE='h20).
module tb_irq_ctrl;

  localparam logic [15:0] A_MASK  = 16'h20;
  localparam logic [15:0] A_MODE  = 16'h21;
  localparam logic [15:0] A_PEND  = 16'h22;
  localparam logic [15:0] A_CAUSE = 16'h23;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_irq;
  logic        i_irq_en, i_sys, i_trap, i_mem_exception;
  logic [15:0] i_sr_addr, i_sr_data;
  logic        i_sr_we;
  logic [15:0] o_sr_data, o_cause;
  logic        o_sr_hit, o_irq;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  irq_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_irq(i_irq), .i_irq_en(i_irq_en),
    .i_sys(i_sys), .i_trap(i_trap), .i_mem_exception(i_mem_exception),
    .i_sr_addr(i_sr_addr), .i_sr_data(i_sr_data), .i_sr_we(i_sr_we),
    .o_sr_data(o_sr_data), .o_sr_hit(o_sr_hit), .o_irq(o_irq), .o_cause(o_cause)
  );

  always #10 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sr_write(input logic [15:0] a, input logic [15:0] d);
    i_sr_addr = a;
    i_sr_data = d;
    i_sr_we   = 1'b1;
    tick();
    i_sr_we   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input string tag, input logic [15:0] exp);
    i_sr_addr = a;
    #1;
    check(tag, o_sr_data, exp);
  endtask

  task automatic irq_chk(input string tag, input logic exp_irq, input logic [15:0] exp_cause);
    #1;
    check({tag, "_irq"}, {15'd0, o_irq}, {15'd0, exp_irq});
    check({tag, "_cause"}, o_cause, exp_cause);
  endtask

  initial begin
    i_rst = 1'b1; i_irq = '0; i_irq_en = 1'b0; i_sys = 1'b0; i_trap = 1'b0;
    i_mem_exception = 1'b0; i_sr_addr = '0; i_sr_data = '0; i_sr_we = 1'b0;
    tick(); tick();
    i_rst = 1'b0;

    // Reset state and decode
    irq_chk("rst", 1'b0, 16'd0);
    rd(A_MASK,  "rst_mask",  16'h0);
    rd(A_MODE,  "rst_mode",  16'h0);
    rd(A_PEND,  "rst_pend",  16'h0);
    rd(A_CAUSE, "rst_cause", 16'h0);
    check("hit_base", {15'd0, o_sr_hit}, 16'd1);
    i_sr_addr = 16'h25; #1;
    check("hit_out", {15'd0, o_sr_hit}, 16'd0);
    check("data_out", o_sr_data, 16'd0);

    // Edge line 3: one-cycle pulse -> take three cycles later
    sr_write(A_MODE, 16'h08);
    sr_write(A_MASK, 16'h08);
    i_irq_en = 1'b1;
    i_irq = 8'h08; tick(); i_irq = 8'h00;
    irq_chk("e3_c1", 1'b0, 16'd0);
    tick();
    irq_chk("e3_c2", 1'b0, 16'd0);
    tick();
    irq_chk("e3_c3", 1'b1, 16'd7);
    tick();
    rd(A_CAUSE, "e3_cause", 16'd7);
    rd(A_PEND,  "e3_pend",  16'h00);
    irq_chk("e3_after", 1'b0, 16'd0);

    // Level line 1 and edge line 5 both pending
    i_irq_en = 1'b0;
    sr_write(A_MODE, 16'h20);
    sr_write(A_MASK, 16'h22);
    i_irq = 8'h22; tick(); i_irq = 8'h02; tick(); tick();
    rd(A_PEND, "lv_pend", 16'h22);
    irq_chk("lv_dis", 1'b0, 16'd0);
    i_irq_en = 1'b1;
    irq_chk("lv_en", 1'b1, 16'd5);
    tick();
    i_irq_en = 1'b0;
    rd(A_CAUSE, "lv_cause", 16'd5);
    i_irq_en = 1'b1;
    irq_chk("lv_retake", 1'b1, 16'd5);
    sr_write(A_PEND, 16'h02);
    rd(A_PEND, "lv_w1c", 16'h22);
    i_irq = 8'h00; tick(); tick();
    irq_chk("e5_take", 1'b1, 16'd9);
    i_irq_en = 1'b0;
    sr_write(A_PEND, 16'h20);
    rd(A_PEND, "e5_w1c", 16'h00);

    // Edge line 0 pending while masked, then unmasked
    sr_write(A_MASK, 16'h00);
    sr_write(A_MODE, 16'h01);
    i_irq_en = 1'b1;
    i_irq = 8'h01; tick(); i_irq = 8'h00; tick(); tick();
    rd(A_PEND, "m0_pend", 16'h01);
    irq_chk("m0_masked", 1'b0, 16'd0);
    sr_write(A_MASK, 16'h01);
    irq_chk("m0_unmask", 1'b1, 16'd4);
    i_irq_en = 1'b0;
    i_irq = 8'h01; tick(); i_irq = 8'h00; tick();
    sr_write(A_PEND, 16'h01);
    rd(A_PEND, "m0_setwins", 16'h01);
    sr_write(A_PEND, 16'h01);
    rd(A_PEND, "m0_w1c", 16'h00);

    // Synchronous exceptions ignore enable and mask
    sr_write(A_MODE, 16'h00);
    i_irq = 8'h01; tick(); tick();
    irq_chk("ex_blocked", 1'b0, 16'd0);
    i_trap = 1'b1;
    irq_chk("ex_trap", 1'b1, 16'd1);
    tick();
    rd(A_CAUSE, "ex_trap_reg", 16'd1);
    i_trap = 1'b0; i_mem_exception = 1'b1; i_sys = 1'b1;
    irq_chk("ex_mem_sys", 1'b1, 16'd0);
    i_mem_exception = 1'b0;
    irq_chk("ex_sys", 1'b1, 16'd2);
    tick();
    rd(A_CAUSE, "ex_sys_reg", 16'd2);
    i_sys = 1'b0;

    // Reset while edge bits pending and o_irq high
    i_irq = 8'h00; tick(); tick(); tick();
    sr_write(A_MODE, 16'h06);
    sr_write(A_MASK, 16'h06);
    i_irq = 8'h06; tick(); i_irq = 8'h00; tick(); tick();
    rd(A_PEND, "rs_pend", 16'h06);
    i_irq_en = 1'b1;
    irq_chk("rs_pre", 1'b1, 16'd5);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    rd(A_MASK,  "rs_mask",  16'h0);
    rd(A_MODE,  "rs_mode",  16'h0);
    rd(A_PEND,  "rs_pend0", 16'h0);
    rd(A_CAUSE, "rs_cause", 16'h0);
    irq_chk("rs_irq", 1'b0, 16'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      irq_chk("rs_quiet", 1'b0, 16'd0);
    end
    rd(A_CAUSE, "rs_cause_end", 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
